acq_sequencer: RTL and testbench
================================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 SHALL have parameter MAXCNTSIZE, default 28, meaning acquisition-cycle counter width.
REQ-002 SHALL have parameter DATA_SIZE, default 8, meaning FIFO/TX word width (>=8).
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning max data words per readout burst (>=1).
REQ-004 SHALL have one clock; reset is asynchronous and active-low. Ports are listed below.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin timed acquisition.
- stop  in  1  one-cycle pulse: end acquisition early or end indefinite acquisition.
- trig_reset  in  1  one-cycle pulse: synchronous abort of everything.
- max_cnt  in  MAXCNTSIZE  acquisition length in clk cycles; 0 = indefinite.
- send_burst  in  1  one-cycle pulse: drain up to BURST_LEN FIFO words to TX.
- fifo_empty  in  1  correlator FIFO empty flag.
- fifo_dout  in  DATA_SIZE  FIFO read data, valid 1 cycle after fifo_rd_en.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- acq_enable  out  1  enables correlator counters.
- cnt_finished  out  1  sticky: timed acquisition completed.
- fifo_rd_en  out  1  one-cycle FIFO pop.
- tx_valid  out  1  tx_data valid.
- tx_data  out  DATA_SIZE  word to transmitter.
- burst_done  out  1  one-cycle pulse: burst complete.
- busy  out  1  high when drain FSM is not D_IDLE.

Function
REQ-005 SHALL run an acquisition timer independently of, and concurrently with, the drain FSM.
REQ-006 SHALL, on start with acq_enable=0, capture max_cnt, clear the cycle counter and cnt_finished, and assert acq_enable from the next cycle.
REQ-007 SHALL ignore start while acq_enable=1.
REQ-008 SHALL, with captured max_cnt=N>0, hold acq_enable high for exactly N cycles, then drop it and set cnt_finished in the same cycle.
REQ-009 SHALL, with captured max_cnt=0, hold acq_enable until stop or trig_reset and never set cnt_finished.
REQ-010 SHALL, on stop, clear acq_enable next cycle without setting cnt_finished; stop SHALL win over start in the same cycle.
REQ-011 SHALL ignore max_cnt changes during acquisition.
REQ-012 SHALL implement the drain FSM with states D_IDLE, D_REQ, D_WAIT, D_SEND (plus D_HDR, see Configuration).
REQ-013 SHALL move D_IDLE->D_REQ on send_burst, clearing the word count; send_burst outside D_IDLE SHALL be ignored.
REQ-014 SHALL, in D_REQ, go to D_IDLE with a burst_done pulse if fifo_empty; otherwise it SHALL pulse fifo_rd_en for one cycle and go to D_WAIT.
REQ-015 SHALL, in D_WAIT, register fifo_dout into tx_data, assert tx_valid, and go to D_SEND.
REQ-016 SHALL hold tx_data/tx_valid stable in D_SEND until tx_ready=1; on acceptance it SHALL drop tx_valid and increment the count. It SHALL go to D_IDLE with burst_done if count reaches BURST_LEN, else to D_REQ.
REQ-017 SHALL produce at most one fifo_rd_en per transmitted data word and never pop while fifo_empty=1.

Reset
REQ-018 SHALL, on rst_n=0, drive all outputs to 0, the timer counter to 0, and the drain FSM to D_IDLE, with no clock required.
REQ-019 SHALL, on trig_reset, perform the same clearing synchronously on the next edge, aborting any burst mid-word without a burst_done pulse. trig_reset SHALL override start, stop and send_burst in the same cycle.

Configuration
REQ-020 SHALL, with macro ACQ_SEQ_HEADER_EN defined, enter D_HDR on send_burst. D_HDR SHALL present tx_data=8'hA5, zero-extended, with tx_valid=1. It SHALL go to D_REQ on tx_ready. This happens even when the FIFO is empty, and the header SHALL not count toward BURST_LEN.
REQ-021 SHALL, without ACQ_SEQ_HEADER_EN, omit D_HDR, so a burst on an empty FIFO transmits nothing.

Verification
REQ-022 max_cnt=5, start pulse -> acq_enable high for exactly 5 cycles, then cnt_finished=1 and stays 1.
REQ-023 max_cnt=0, start, 100 cycles later stop -> acq_enable high 100 cycles, cnt_finished stays 0; start+stop same cycle -> acq_enable stays 0.
REQ-024 FIFO holds 0x11,0x22,0x33, BURST_LEN=16, tx_ready=1, send_burst -> tx_data 0x11,0x22,0x33, 3 fifo_rd_en pulses, burst_done after empty.
REQ-025 FIFO holds 20 words, tx_ready toggling 1-of-3 cycles -> exactly 16 words sent, tx_data stable while stalled, 4 words remain.
REQ-026 trig_reset during D_SEND with acq_enable=1 -> next cycle tx_valid=0, acq_enable=0, busy=0, no burst_done; rst_n low mid-burst -> all outputs 0 immediately.
REQ-027 ACQ_SEQ_HEADER_EN defined, empty FIFO, send_burst -> single 0xA5 transmitted, then burst_done.

Source files
------------

// File: rtl/acq_sequencer.sv
// Acquisition timer plus FIFO-to-TX burst drain engine; the two run concurrently.
// Defining ACQ_SEQ_HEADER_EN prefixes every burst with a 0xA5 header word.
module acq_sequencer #(
  parameter int MAXCNTSIZE = 28,
  parameter int DATA_SIZE  = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  trig_reset,
  input  logic [MAXCNTSIZE-1:0] max_cnt,
  input  logic                  send_burst,
  input  logic                  fifo_empty,
  input  logic [DATA_SIZE-1:0]  fifo_dout,
  input  logic                  tx_ready,
  output logic                  acq_enable,
  output logic                  cnt_finished,
  output logic                  fifo_rd_en,
  output logic                  tx_valid,
  output logic [DATA_SIZE-1:0]  tx_data,
  output logic                  burst_done,
  output logic                  busy
);

  localparam int CW = $clog2(BURST_LEN + 1);

`ifdef ACQ_SEQ_HEADER_EN
  typedef enum logic [2:0] {D_IDLE, D_REQ, D_WAIT, D_SEND, D_HDR} drainState_t;
`else
  typedef enum logic [2:0] {D_IDLE, D_REQ, D_WAIT, D_SEND} drainState_t;
`endif

  // ---------------- acquisition timer ----------------
  logic [MAXCNTSIZE-1:0] cycleCnt;
  logic [MAXCNTSIZE-1:0] maxCntLatched;
  logic [MAXCNTSIZE-1:0] cycleCntInc;
  logic                  acqEnableReg;
  logic                  cntFinishedReg;

  assign cycleCntInc = cycleCnt + MAXCNTSIZE'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt       <= '0;
      maxCntLatched  <= '0;
      acqEnableReg   <= 1'b0;
      cntFinishedReg <= 1'b0;
    end else if (trig_reset) begin
      cycleCnt       <= '0;
      maxCntLatched  <= '0;
      acqEnableReg   <= 1'b0;
      cntFinishedReg <= 1'b0;
    end else if (stop) begin
      acqEnableReg <= 1'b0;
    end else if (start && !acqEnableReg) begin
      maxCntLatched  <= max_cnt;
      cycleCnt       <= '0;
      cntFinishedReg <= 1'b0;
      acqEnableReg   <= 1'b1;
    end else if (acqEnableReg && (maxCntLatched != '0)) begin
      // A latched length of zero means run until stopped, so the counter only matters when nonzero.
      cycleCnt <= cycleCntInc;
      if (cycleCntInc == maxCntLatched) begin
        acqEnableReg   <= 1'b0;
        cntFinishedReg <= 1'b1;
      end
    end
  end

  // ---------------- drain FSM ----------------
  drainState_t          stateReg, stateNext;
  logic [CW-1:0]        wordCntReg, wordCntNext;
  logic [DATA_SIZE-1:0] txDataReg, txDataNext;
  logic                 txValidReg, txValidNext;
  logic                 burstDoneReg, burstDoneNext;
  logic                 fifoRdEn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= D_IDLE;
      wordCntReg   <= '0;
      txDataReg    <= '0;
      txValidReg   <= 1'b0;
      burstDoneReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      wordCntReg   <= wordCntNext;
      txDataReg    <= txDataNext;
      txValidReg   <= txValidNext;
      burstDoneReg <= burstDoneNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    wordCntNext   = wordCntReg;
    txDataNext    = txDataReg;
    txValidNext   = txValidReg;
    burstDoneNext = 1'b0;
    fifoRdEn      = 1'b0;
    if (trig_reset) begin
      stateNext   = D_IDLE;
      wordCntNext = '0;
      txDataNext  = '0;
      txValidNext = 1'b0;
    end else begin
      case (stateReg)
        D_IDLE: begin
          if (send_burst) begin
            wordCntNext = '0;
`ifdef ACQ_SEQ_HEADER_EN
            stateNext   = D_HDR;
            txDataNext  = DATA_SIZE'(8'hA5);
            txValidNext = 1'b1;
`else
            stateNext   = D_REQ;
`endif
          end
        end
        D_REQ: begin
          if (fifo_empty) begin
            stateNext     = D_IDLE;
            burstDoneNext = 1'b1;
          end else begin
            fifoRdEn  = 1'b1;
            stateNext = D_WAIT;
          end
        end
        D_WAIT: begin
          // FIFO read data is valid one cycle after the pop.
          txDataNext  = fifo_dout;
          txValidNext = 1'b1;
          stateNext   = D_SEND;
        end
        D_SEND: begin
          if (tx_ready) begin
            txValidNext = 1'b0;
            wordCntNext = wordCntReg + CW'(1);
            if (wordCntNext == CW'(BURST_LEN)) begin
              stateNext     = D_IDLE;
              burstDoneNext = 1'b1;
            end else begin
              stateNext = D_REQ;
            end
          end
        end
`ifdef ACQ_SEQ_HEADER_EN
        D_HDR: begin
          if (tx_ready) begin
            txValidNext = 1'b0;
            stateNext   = D_REQ;
          end
        end
`endif
        default: stateNext = D_IDLE;
      endcase
    end
  end

  assign acq_enable   = acqEnableReg;
  assign cnt_finished = cntFinishedReg;
  assign fifo_rd_en   = fifoRdEn;
  assign tx_valid     = txValidReg;
  assign tx_data      = txDataReg;
  assign burst_done   = burstDoneReg;
  assign busy         = (stateReg != D_IDLE);

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: directed stimulus pushes expected TX words,
// a negedge monitor pops and compares on every accepted transfer.
module tb_acq_sequencer;
  localparam int MCS = 28;
  localparam int DW  = 8;
  localparam int BL  = 16;
`ifdef ACQ_SEQ_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0, stop = 1'b0, trig_reset = 1'b0, send_burst = 1'b0;
  logic [MCS-1:0] max_cnt = '0;
  logic           fifo_empty = 1'b1;
  logic [DW-1:0]  fifo_dout = '0;
  logic           tx_ready;
  logic           acq_enable, cnt_finished, fifo_rd_en, tx_valid, burst_done, busy;
  logic [DW-1:0]  tx_data;

  logic           readyLevel = 1'b0;
  logic           readyToggle = 1'b0;
  logic           toggleReady = 1'b0;
  int             cyc = 0;

  assign tx_ready = readyToggle ? toggleReady : readyLevel;

  acq_sequencer #(.MAXCNTSIZE(MCS), .DATA_SIZE(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .trig_reset(trig_reset),
    .max_cnt(max_cnt), .send_burst(send_burst), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .tx_ready(tx_ready), .acq_enable(acq_enable),
    .cnt_finished(cnt_finished), .fifo_rd_en(fifo_rd_en), .tx_valid(tx_valid),
    .tx_data(tx_data), .burst_done(burst_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] fifoQ[$];
  int acqCnt = 0, rdCnt = 0, doneCnt = 0, txCnt = 0;
  logic          stallValid = 1'b0;
  logic [DW-1:0] stallData = '0;

  // FIFO model: data appears one cycle after a pop, empty flag tracks remaining words.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    toggleReady <= ((cyc % 3) == 0);
    if (fifo_rd_en && fifoQ.size() > 0) fifo_dout <= fifoQ.pop_front();
    fifo_empty <= (fifoQ.size() == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (acq_enable) acqCnt++;
      if (burst_done) doneCnt++;
      if (fifo_rd_en) begin
        rdCnt++;
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL pop_on_empty: fifo_rd_en=1 while fifo_empty=1 (required no pop)");
        end
      end
      if (stallValid) begin
        checks++;
        if (!tx_valid || tx_data !== stallData) begin
          errors++;
          $display("FAIL stall_hold: tx_valid=%0b tx_data=%02h, required 1/%02h", tx_valid, tx_data, stallData);
        end
      end
      if (tx_valid && tx_ready) begin
        checks++;
        txCnt++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got %02h, required no transfer", tx_data);
        end else begin
          logic [DW-1:0] exp;
          exp = expQ.pop_front();
          if (tx_data !== exp) begin
            errors++;
            $display("FAIL tx_word: got %02h, required %02h", tx_data, exp);
          end else begin
            $display("tx word %02h ok", tx_data);
          end
        end
      end
      stallValid = tx_valid && !tx_ready && !trig_reset;
      stallData  = tx_data;
    end else begin
      stallValid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0: start = v;
      1: stop = v;
      2: send_burst = v;
      3: trig_reset = v;
      default: ;
    endcase
  endtask

  task automatic pulse(input int sel);
    @(posedge clk); #1 drive(sel, 1'b1);
    @(posedge clk); #1 drive(sel, 1'b0);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_acq_enable"}, 64'(acq_enable), 64'd0);
    chk({tag, "_cnt_finished"}, 64'(cnt_finished), 64'd0);
    chk({tag, "_fifo_rd_en"}, 64'(fifo_rd_en), 64'd0);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
    chk({tag, "_burst_done"}, 64'(burst_done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic waitDone(input int target, input int budget);
    int i;
    i = 0;
    while (doneCnt < target && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    checks++;
    if (doneCnt < target) begin
      errors++;
      $display("FAIL burst_done_timeout: count %0d, required %0d", doneCnt, target);
    end
  endtask

  task automatic waitTxValid(input int budget);
    int i;
    i = 0;
    while (!tx_valid && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    checks++;
    if (!tx_valid) begin
      errors++;
      $display("FAIL tx_valid_timeout: tx_valid=0, required 1");
    end
  endtask

  initial begin
    int a0, r0, d0, t0;
    repeat (3) @(posedge clk);
    #1 chkAllZero("reset");
    rst_n = 1'b1;

    // Timed acquisition of 5 cycles; a max_cnt change mid-run must be ignored.
    max_cnt = 28'd5;
    a0 = acqCnt;
    pulse(0);
    max_cnt = 28'd2;
    repeat (4) @(posedge clk);
    #1 chk("t5_acq_last", 64'(acq_enable), 64'd1);
    chk("t5_fin_before", 64'(cnt_finished), 64'd0);
    @(posedge clk); #1;
    chk("t5_acq_drop", 64'(acq_enable), 64'd0);
    chk("t5_fin_set", 64'(cnt_finished), 64'd1);
    repeat (10) @(posedge clk);
    #1 chk("t5_cycles", 64'(acqCnt - a0), 64'd5);
    chk("t5_fin_sticky", 64'(cnt_finished), 64'd1);

    // Indefinite acquisition stopped after 100 cycles.
    max_cnt = 28'd0;
    a0 = acqCnt;
    pulse(0);
    chk("inf_fin_cleared", 64'(cnt_finished), 64'd0);
    repeat (98) @(posedge clk);
    pulse(1);
    chk("inf_acq_off", 64'(acq_enable), 64'd0);
    chk("inf_cycles", 64'(acqCnt - a0), 64'd100);
    chk("inf_fin", 64'(cnt_finished), 64'd0);

    // Start and stop together: stop wins.
    a0 = acqCnt;
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("startstop_cycles", 64'(acqCnt - a0), 64'd0);

    // A second start during a 3-cycle acquisition is ignored.
    a0 = acqCnt;
    max_cnt = 28'd3;
    pulse(0);
    max_cnt = 28'd10;
    pulse(0);
    repeat (15) @(posedge clk);
    #1 chk("restart_ignored_cycles", 64'(acqCnt - a0), 64'd3);
    chk("restart_fin", 64'(cnt_finished), 64'd1);

    // Three-word burst with tx_ready held high.
    fifoQ = '{8'h11, 8'h22, 8'h33};
    readyLevel = 1'b1;
    repeat (2) @(posedge clk);
    r0 = rdCnt; d0 = doneCnt; t0 = txCnt;
    if (HDR != 0) expQ.push_back(8'hA5);
    expQ.push_back(8'h11); expQ.push_back(8'h22); expQ.push_back(8'h33);
    pulse(2);
    waitDone(d0 + 1, 200);
    repeat (2) @(posedge clk);
    #1 chk("b3_rd_pulses", 64'(rdCnt - r0), 64'd3);
    chk("b3_words", 64'(txCnt - t0), 64'(3 + HDR));
    chk("b3_done_count", 64'(doneCnt - d0), 64'd1);
    chk("b3_busy", 64'(busy), 64'd0);
    chk("b3_exp_left", 64'(expQ.size()), 64'd0);

    // Twenty words with tx_ready high one cycle in three: burst stops at BURST_LEN.
    for (int i = 0; i < 20; i++) fifoQ.push_back(DW'(8'h40 + i));
    readyToggle = 1'b1;
    repeat (2) @(posedge clk);
    r0 = rdCnt; d0 = doneCnt; t0 = txCnt;
    if (HDR != 0) expQ.push_back(8'hA5);
    for (int i = 0; i < BL; i++) expQ.push_back(DW'(8'h40 + i));
    pulse(2);
    waitDone(d0 + 1, 600);
    repeat (2) @(posedge clk);
    #1 chk("b16_words", 64'(txCnt - t0), 64'(BL + HDR));
    chk("b16_rd_pulses", 64'(rdCnt - r0), 64'(BL));
    chk("b16_fifo_left", 64'(fifoQ.size()), 64'd4);
    chk("b16_exp_left", 64'(expQ.size()), 64'd0);
    readyToggle = 1'b0;
    readyLevel = 1'b0;
    fifoQ.delete();

    // trig_reset while a word is stalled in the TX stage with acquisition running.
    max_cnt = 28'd0;
    pulse(0);
    fifoQ = '{8'h5A, 8'h6B};
    repeat (2) @(posedge clk);
    d0 = doneCnt;
    pulse(2);
    waitTxValid(50);
    @(posedge clk); #1 trig_reset = 1'b1; start = 1'b1;
    @(posedge clk); #1 trig_reset = 1'b0; start = 1'b0;
    chk("trig_tx_valid", 64'(tx_valid), 64'd0);
    chk("trig_acq", 64'(acq_enable), 64'd0);
    chk("trig_busy", 64'(busy), 64'd0);
    chk("trig_tx_data", 64'(tx_data), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("trig_no_done", 64'(doneCnt - d0), 64'd0);
    chk("trig_acq_stays_off", 64'(acq_enable), 64'd0);
    fifoQ.delete();

    // Asynchronous reset mid-burst clears outputs without a clock edge.
    pulse(0);
    fifoQ = '{8'h77};
    repeat (2) @(posedge clk);
    pulse(2);
    waitTxValid(50);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chkAllZero("async");
    @(posedge clk); #1 rst_n = 1'b1;
    fifoQ.delete();
    repeat (3) @(posedge clk);
    #1 chk("final_exp_left", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
